// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl
// Match-level controller for the pong game: key conditioning, serve delay,
// score keeping, pause handling and win detection for PLAYERS_N players.
// Every output is driven straight from a flop.

module pong_match_ctrl #(
    parameter int KEYS_W       = 4,
    parameter int PLAYERS_N    = 2,
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int START_KEY    = 0,
    parameter int PAUSE_KEY    = 1,
    localparam int PW          = $clog2(PLAYERS_N),
    localparam int CNT_W       = $clog2(SERVE_FRAMES + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [KEYS_W-1:0]              keys_i,
    input  logic                           new_frame_i,
    input  logic [PLAYERS_N-1:0]           point_i,
    output logic                           run_o,
    output logic                           ball_reset_o,
    output logic [PW-1:0]                  serve_player_o,
    output logic [PLAYERS_N*SCORE_W-1:0]   score_o,
    output logic [2:0]                     state_o,
    output logic [PW-1:0]                  winner_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    // Bit positions inside the conditioned key vectors.
    localparam int K_START = 0;
    localparam int K_PAUSE = 1;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [PW-1:0] lowest_set(input logic [PLAYERS_N-1:0] vec);
        logic [PW-1:0] idx;
        idx = '0;
        for (int i = PLAYERS_N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = PW'(i);
            end
        end
        return idx;
    endfunction

    state_t                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [PLAYERS_N*SCORE_W-1:0]   score_q, score_d;
    logic [PW-1:0]                  serve_q, serve_d;
    logic [PW-1:0]                  winner_q, winner_d;
    logic                           run_q, run_d;
    logic                           ball_reset_q, ball_reset_d;

    logic [1:0]                     key_meta_q, key_meta_d;
    logic [1:0]                     key_sync_q, key_sync_d;
    logic [1:0]                     key_prev_q, key_prev_d;

    logic [1:0]                     key_raw_s;
    logic [1:0]                     key_edge_s;
    logic [PW-1:0]                  scorer_s;
    logic [SCORE_W-1:0]             cur_score_s;
    logic [SCORE_W-1:0]             new_score_s;
    logic [CNT_W-1:0]               cnt_inc_s;
    logic                           unused_keys_s;

    // Only the start and pause keys matter; the rest are folded into a sink.
    assign key_raw_s     = {keys_i[PAUSE_KEY], keys_i[START_KEY]};
    assign unused_keys_s = ^keys_i;

    assign key_edge_s  = key_sync_q & ~key_prev_q;
    assign scorer_s    = lowest_set(point_i);
    assign cur_score_s = score_q[scorer_s*SCORE_W +: SCORE_W];
    assign new_score_s = cur_score_s + SCORE_W'(1);
    assign cnt_inc_s   = cnt_q + CNT_W'(1);

    // Next-state logic for the key pipeline, match FSM, counters and outputs.
    always_comb begin
        key_meta_d   = key_raw_s;
        key_sync_d   = key_meta_q;
        key_prev_d   = key_sync_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        score_d      = score_q;
        serve_d      = serve_q;
        winner_d     = winner_q;

        case (state_q)
            ST_IDLE: begin
                if (key_edge_s[K_START]) begin
                    state_d = ST_SERVE;
                    score_d = '0;
                    serve_d = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVE: begin
                if (new_frame_i) begin
                    if (cnt_inc_s == CNT_W'(SERVE_FRAMES)) begin
                        state_d = ST_PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc_s;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_PLAY: begin
                // A point outranks a pause request arriving in the same cycle.
                if (|point_i) begin
                    score_d[scorer_s*SCORE_W +: SCORE_W] = new_score_s;
                    serve_d = scorer_s;
                    cnt_d   = '0;
                    if (new_score_s == SCORE_W'(WIN_SCORE)) begin
                        state_d  = ST_OVER;
                        winner_d = scorer_s;
                    end else begin
                        state_d  = ST_SERVE;
                    end
                end else if (key_edge_s[K_PAUSE]) begin
                    state_d = ST_PAUSE;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_PAUSE: begin
                if (key_edge_s[K_PAUSE]) begin
                    state_d = ST_PLAY;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_OVER: begin
                if (key_edge_s[K_START]) begin
                    state_d = ST_SERVE;
                    score_d = '0;
                    serve_d = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_OVER;
                end
            end
            default: begin
                // Illegal encoding: fall back to a clean idle match.
                state_d  = ST_IDLE;
                cnt_d    = '0;
                score_d  = '0;
                serve_d  = '0;
                winner_d = '0;
            end
        endcase

        // Ball runs from the cycle after PLAY entry and stops on the exit edge.
        run_d        = (state_q == ST_PLAY) && (state_d == ST_PLAY);
        // One-cycle pulse coinciding with every entry into SERVE.
        ball_reset_d = (state_d == ST_SERVE) && (state_q != ST_SERVE);
    end

    // State, counter, score and output registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            score_q      <= '0;
            serve_q      <= '0;
            winner_q     <= '0;
            run_q        <= 1'b0;
            ball_reset_q <= 1'b0;
            key_meta_q   <= 2'b00;
            key_sync_q   <= 2'b00;
            key_prev_q   <= 2'b00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            score_q      <= score_d;
            serve_q      <= serve_d;
            winner_q     <= winner_d;
            run_q        <= run_d;
            ball_reset_q <= ball_reset_d;
            key_meta_q   <= key_meta_d;
            key_sync_q   <= key_sync_d;
            key_prev_q   <= key_prev_d;
        end
    end

    assign run_o          = run_q;
    assign ball_reset_o   = ball_reset_q;
    assign serve_player_o = serve_q;
    assign score_o        = score_q;
    assign state_o        = state_q;
    assign winner_o       = winner_q;

endmodule
